conv2d_window_gen: RTL

- Streaming window generator that drives the conv2d MAC array's window input.
- Accepts a raster-order multi-channel image, PIX_PER_CLK pixels per beat, and buffers WIN_SIZE-1 rows in line buffers.
- Emits "same"-padded (zero border) WIN_SIZE x WIN_SIZE windows for PIX_PER_CLK adjacent output pixels per out_valid, in the [lane][channel][row][col] layout the MAC array consumes.

---
 rtl/conv2d_window_gen.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/conv2d_window_gen.sv
// conv2d_window_gen
// Streaming window generator feeding the conv2d MAC array. Takes a raster-order,
// multi-channel image PIX_PER_CLK pixels per beat, keeps WIN_SIZE-1 rows in line
// buffers and emits zero-padded ("same") WIN_SIZE x WIN_SIZE windows for
// PIX_PER_CLK adjacent output pixels per out_valid pulse.
// Intended for WIN_SIZE >= 3 (odd), PAD <= PIX_PER_CLK, IMG_W multiple of
// PIX_PER_CLK, IMG_H > PAD.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_pix     [lane][chan] pixels of the current input beat
//   out_valid  single-cycle window bus valid (no back-pressure)
//   window     [lane][chan][row][col] windows for one output beat
//   out_last   high with the final output beat of a frame
module conv2d_window_gen #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WIN_SIZE    = 3,
  parameter int unsigned PIX_PER_CLK = 8,
  parameter int unsigned CIN         = 8,
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 32
) (
  input  logic                                                                     clk,
  input  logic                                                                     rst,
  input  logic                                                                     in_valid,
  output logic                                                                     in_ready,
  input  logic signed [PIX_PER_CLK-1:0][CIN-1:0][DATA_W-1:0]                       in_pix,
  output logic                                                                     out_valid,
  output logic signed [PIX_PER_CLK-1:0][CIN-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_W-1:0] window,
  output logic                                                                     out_last
);

  localparam int unsigned PAD     = (WIN_SIZE - 1) / 2;
  localparam int unsigned BEATS   = IMG_W / PIX_PER_CLK;
  localparam int unsigned LB_ROWS = WIN_SIZE - 1;
  localparam int unsigned BX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RY_W    = $clog2(IMG_H + PAD + 1);

  localparam logic [BX_W-1:0] BxLast      = BX_W'(BEATS - 1);
  localparam logic [RY_W-1:0] RyImgLast   = RY_W'(IMG_H - 1);
  localparam logic [RY_W-1:0] RyFlushLast = RY_W'(IMG_H + PAD - 1);
  localparam logic [RY_W-1:0] RyFirstOut  = RY_W'(PAD);

  typedef logic [PIX_PER_CLK-1:0][CIN-1:0][DATA_W-1:0] beat_t;
  typedef logic [PIX_PER_CLK-1:0][CIN-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_W-1:0] win_t;

  typedef enum logic [1:0] {StRun, StTail, StFlush} state_e;

  state_e          state_q, state_d;
  logic [BX_W-1:0] bx_q, bx_d;
  // Rows IMG_H .. IMG_H+PAD-1 are the synthetic all-zero flush rows.
  logic [RY_W-1:0] ry_q, ry_d;

  logic      beat_step;   // a real or synthetic beat enters the pipeline
  logic      tail_step;   // end-of-row cycle, emits the rightmost output beat
  logic      emit;
  logic      last;
  logic [BX_W-1:0] ox;
  logic      left_ok, right_ok;
  logic [WIN_SIZE-1:0] row_ok;
  beat_t     beat_in;

  beat_t     lb_q [LB_ROWS][BEATS];   // lb_q[0] is the most recent completed row
  beat_t     sr_q [WIN_SIZE][2];      // [row][0]=beat ox-1, [row][1]=beat ox
  beat_t     col_new [WIN_SIZE];      // column group of the beat entering now (beat ox+1)

  win_t      window_d, window_q;
  logic      out_valid_q, out_last_q;

  assign in_ready  = (state_q == StRun);
  assign beat_step = ((state_q == StRun) && in_valid) || (state_q == StFlush);
  assign tail_step = (state_q == StTail);
  assign beat_in   = (state_q == StRun) ? beat_t'(in_pix) : '0;

  // FSM and beat/row counters
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    ry_d    = ry_q;
    unique case (state_q)
      StRun, StFlush: begin
        if (beat_step) begin
          if (bx_q == BxLast) begin
            bx_d    = '0;
            state_d = StTail;
          end else begin
            bx_d = bx_q + 1'b1;
          end
        end
      end
      StTail: begin
        if (ry_q == RyFlushLast) begin
          ry_d    = '0;
          state_d = StRun;
        end else begin
          ry_d    = ry_q + 1'b1;
          state_d = (ry_q >= RyImgLast) ? StFlush : StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      bx_q    <= '0;
      ry_q    <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      ry_q    <= ry_d;
    end
  end

  // Output beat lags the input by one beat so the right neighbours are available.
  assign emit     = (ry_q >= RyFirstOut) && (tail_step || (beat_step && (bx_q != '0)));
  assign last     = tail_step && (ry_q == RyFlushLast);
  assign ox       = tail_step ? BxLast : (bx_q - 1'b1);
  assign left_ok  = (ox != '0);
  assign right_ok = (ox != BxLast);

  // Window row i is image row ry-2*PAD+i; mask rows outside the image so stale
  // line-buffer contents never leak through.
  for (genvar i = 0; i < WIN_SIZE; i++) begin : g_row_ok
    assign row_ok[i] = (32'(ry_q) + 32'(i) >= 32'(2 * PAD)) &&
                       (32'(ry_q) + 32'(i) <  32'(IMG_H + 2 * PAD));
  end

  for (genvar i = 0; i < WIN_SIZE - 1; i++) begin : g_col_lb
    assign col_new[i] = tail_step ? '0 : lb_q[WIN_SIZE-2-i][bx_q];
  end
  assign col_new[WIN_SIZE-1] = tail_step ? '0 : beat_in;

  // Line buffers shift down one row at the current beat column.
  always_ff @(posedge clk) begin
    if (beat_step) begin
      lb_q[0][bx_q] <= beat_in;
      for (int k = 1; k < LB_ROWS; k++) begin
        lb_q[k][bx_q] <= lb_q[k-1][bx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_step || tail_step) begin
      for (int i = 0; i < WIN_SIZE; i++) begin
        sr_q[i][0] <= sr_q[i][1];
        sr_q[i][1] <= col_new[i];
      end
    end
  end

  // Window assembly: offset M indexes a 3-beat span {left, centre, right}.
  for (genvar l = 0; l < PIX_PER_CLK; l++) begin : g_lane
    for (genvar c = 0; c < CIN; c++) begin : g_chan
      for (genvar i = 0; i < WIN_SIZE; i++) begin : g_wrow
        for (genvar j = 0; j < WIN_SIZE; j++) begin : g_wcol
          localparam int unsigned M = PIX_PER_CLK + l + j - PAD;
          if (M < PIX_PER_CLK) begin : g_left
            assign window_d[l][c][i][j] = (row_ok[i] && left_ok) ?
                                          sr_q[i][0][M][c] : '0;
          end else if (M < 2 * PIX_PER_CLK) begin : g_mid
            assign window_d[l][c][i][j] = row_ok[i] ?
                                          sr_q[i][1][M-PIX_PER_CLK][c] : '0;
          end else begin : g_right
            assign window_d[l][c][i][j] = (row_ok[i] && right_ok) ?
                                          col_new[i][M-2*PIX_PER_CLK][c] : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      window_q    <= '0;
    end else begin
      out_valid_q <= emit;
      out_last_q  <= emit && last;
      if (emit) begin
        window_q <= window_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign window    = window_q;

endmodule
